// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, one-cycle-latency imem requests and a 2-entry
// {instr, pc} queue to decode. Redirects flush the queue and the in-flight fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  input  logic        if_id_ready,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic [31:0]     pc_q, pc_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      occ_q, occ_d;
  ent_t [1:0]      ent_q, ent_d;
  ent_t            new_ent;
  logic            pop, push, push_idx;
  logic [2:0]      load;
  logic            unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  assign if_id_valid = (occ_q != 2'd0);
  assign pop         = if_id_valid & if_id_ready;
  assign push        = inflight_q & ~redirect_valid;

  // Queue slots committed after this edge; issue only if one stays free.
  assign load     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign imem_req = ~rst & ~redirect_valid & (load < 3'd2);
  assign imem_addr = pc_q;

  assign new_ent.instr = imem_rdata;
  assign new_ent.pc    = inflight_pc_q;
  assign push_idx      = (occ_q == 2'd2);

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    occ_d         = occ_q;
    ent_d         = ent_q;
    if (redirect_valid) begin
      pc_d  = {redirect_pc[31:2], 2'b00};
      occ_d = 2'd0;
    end else begin
      if (imem_req) begin
        pc_d          = pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        ent_d[0] = ent_q[1];
        if (push) ent_d[push_idx] = new_ent;
      end else if (push) begin
        ent_d[occ_q[0]] = new_ent;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      occ_q         <= '0;
      ent_q         <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      occ_q         <= occ_d;
      ent_q         <= ent_d;
    end
  end

  assign if_id_instr = ent_q[0].instr;
  assign if_id_pc    = ent_q[0].pc;
  assign if_id_pc4   = ent_q[0].pc + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: straight-line, stall, redirects, wrap, async reset.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic        if_id_ready;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_valid(if_id_valid), .if_id_ready(if_id_ready),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4)
  );

  always #5 clk = ~clk;

  // Memory: word i holds 0x1000_0000 + i; junk when no request was made.
  always @(posedge clk)
    imem_rdata <= imem_req ? 32'h1000_0000 + {2'b00, imem_addr[31:2]} : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic [31:0] pc);
    logic [31:0] e_instr, e_pc4;
    e_instr = 32'h1000_0000 + {2'b00, pc[31:2]};
    e_pc4   = pc + 32'd4;
    chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'd1);
    chk({tag, "_pc"},    if_id_pc,    pc);
    chk({tag, "_instr"}, if_id_instr, e_instr);
    chk({tag, "_pc4"},   if_id_pc4,   e_pc4);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req},    32'd0);
    chk({tag, "_addr"},  imem_addr,            32'h100);
    chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'd0);
    chk({tag, "_instr"}, if_id_instr,          32'd0);
    chk({tag, "_pc"},    if_id_pc,             32'd0);
    chk({tag, "_pc4"},   if_id_pc4,            32'd4);
  endtask

  initial begin
    rst = 1'b1; if_id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    #3;
    chk_reset("rst");

    // cycle 0/1: fetch 0x100, 0x104; nothing at decode yet
    @(negedge clk); rst = 1'b0; #1;
    chk("c0_req", {31'b0, imem_req}, 32'd1);
    chk("c0_addr", imem_addr, 32'h100);
    chk("c0_valid", {31'b0, if_id_valid}, 32'd0);
    @(negedge clk); #1;
    chk("c1_req", {31'b0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'h104);
    chk("c1_valid", {31'b0, if_id_valid}, 32'd0);
    for (int n = 2; n < 4; n++) begin
      @(negedge clk); #1;
      head("line", 32'h100 + 32'(4 * (n - 2)));
      chk("line_req", {31'b0, imem_req}, 32'd1);
    end

    // stall cycles 4..10: head frozen at 0x108, issue stops
    @(negedge clk); if_id_ready = 1'b0; #1;
    head("stall4", 32'h108);
    chk("stall4_req", {31'b0, imem_req}, 32'd0);
    for (int n = 5; n <= 10; n++) begin
      @(negedge clk); #1;
      head("stall", 32'h108);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_addr", imem_addr, 32'h110);
    end
    for (int n = 11; n <= 14; n++) begin
      @(negedge clk); if_id_ready = 1'b1; #1;
      head("resume", 32'h108 + 32'(4 * (n - 11)));
      chk("resume_req", {31'b0, imem_req}, 32'd1);
    end

    // redirect with entry queued and a fetch in flight
    @(negedge clk); if_id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    chk("redir_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk); redirect_valid = 1'b0; if_id_ready = 1'b1; #1;
    chk("redir_t1_req", {31'b0, imem_req}, 32'd1);
    chk("redir_t1_addr", imem_addr, 32'h40);
    chk("redir_t1_valid", {31'b0, if_id_valid}, 32'd0);
    @(negedge clk); #1;
    chk("redir_t2_valid", {31'b0, if_id_valid}, 32'd0);
    chk("redir_t2_addr", imem_addr, 32'h44);
    @(negedge clk); #1;
    head("redir_t3", 32'h40);

    // misaligned redirect
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h47; #1;
    chk("mis_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("mis_addr", imem_addr, 32'h44);
    @(negedge clk); #1;
    chk("mis_t2_valid", {31'b0, if_id_valid}, 32'd0);
    @(negedge clk); #1;
    chk("mis_pc", if_id_pc, 32'h44);
    chk("mis_pc4", if_id_pc4, 32'h48);
    chk("mis_instr", if_id_instr, 32'h1000_0011);

    // wrap at top of address space
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_addr1", imem_addr, 32'h0);
    @(negedge clk); #1;
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_instr", if_id_instr, 32'h4FFF_FFFF);
    @(negedge clk); #1;
    head("wrap_next", 32'h0);

    // back-to-back redirects: last target wins
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
    chk("b2b_req0", {31'b0, imem_req}, 32'd0);
    @(negedge clk); redirect_pc = 32'h300; #1;
    chk("b2b_req1", {31'b0, imem_req}, 32'd0);
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("b2b_addr", imem_addr, 32'h300);
    chk("b2b_t1_valid", {31'b0, if_id_valid}, 32'd0);
    @(negedge clk); #1;
    chk("b2b_t2_valid", {31'b0, if_id_valid}, 32'd0);
    @(negedge clk); #1;
    head("b2b_t3", 32'h300);

    // fill the queue, then async reset between edges
    @(negedge clk); if_id_ready = 1'b0; #1;
    head("fill1", 32'h304);
    @(negedge clk); #1;
    head("fill2", 32'h304);
    chk("fill2_req", {31'b0, imem_req}, 32'd0);
    #2; rst = 1'b1; #1;
    chk_reset("arst");
    @(negedge clk); rst = 1'b0; if_id_ready = 1'b1; #1;
    chk("rs0_req", {31'b0, imem_req}, 32'd1);
    chk("rs0_addr", imem_addr, 32'h100);
    chk("rs0_valid", {31'b0, if_id_valid}, 32'd0);
    @(negedge clk); #1;
    chk("rs1_addr", imem_addr, 32'h104);
    chk("rs1_valid", {31'b0, if_id_valid}, 32'd0);
    @(negedge clk); #1;
    head("rs2", 32'h100);
    @(negedge clk); #1;
    head("rs3", 32'h104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
